// File: rtl/dma_pkg.sv
// dma_pkg: register map, CTRL/STATUS bit positions and FSM states
// shared by the dma_csr_engine slice.
package dma_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_SRC    = 3'd1;
  localparam logic [2:0] REG_DST    = 3'd2;
  localparam logic [2:0] REG_LEN    = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_CNT    = 3'd5;

  localparam int CTRL_START = 0;
  localparam int CTRL_IE    = 1;
  localparam int CTRL_ABORT = 2;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    DONE_ST
  } state_e;

endpackage

// File: rtl/dma_csr_regs.sv
// dma_csr_regs: register-bus decode, CSR storage, W1C and registered rdata.
// Interrupt enable and irq exist only when DMA_IRQ_EN is defined.
module dma_csr_regs
  import dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  input  logic              busy_i,
  input  logic              set_done_i,
  input  logic              set_err_i,
  input  logic              cnt_inc_i,
  output logic              start_o,
  output logic              abort_o,
  output logic [ADDR_W-1:0] src_o,
  output logic [ADDR_W-1:0] dst_o,
  output logic [LEN_W-1:0]  len_o,
  output logic              irq_o
);

  logic [2:0]        idx;
  logic              unused_addr;
  logic              wr_ctrl, wr_stat, cfg_we;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  len_q, cnt_q, cnt_d;
  logic              done_q, done_d, err_q, err_d;
  logic [DATA_W-1:0] rd_val, rdata_q;

  assign idx         = addr[4:2];
  assign unused_addr = ^{addr[ADDR_W-1:5], addr[1:0]};
  assign wr_ctrl     = wr_en && (idx == REG_CTRL);
  assign wr_stat     = wr_en && (idx == REG_STATUS);
  assign cfg_we      = wr_en && !busy_i;

  // ABORT in the same write masks START
  assign start_o = wr_ctrl && wdata[CTRL_START]
                && !wdata[CTRL_ABORT] && !busy_i;
  assign abort_o = wr_ctrl && wdata[CTRL_ABORT] && busy_i;

  assign src_o = src_q;
  assign dst_o = dst_q;
  assign len_o = len_q;
  assign rdata = rdata_q;

  always_comb begin
    done_d = done_q;
    err_d  = err_q;
    cnt_d  = cnt_q;
    if (start_o) begin
      done_d = 1'b0;
      err_d  = 1'b0;
      cnt_d  = '0;
    end
    if (wr_stat && wdata[ST_DONE]) done_d = 1'b0;
    if (wr_stat && wdata[ST_ERR])  err_d  = 1'b0;
    if (set_done_i) done_d = 1'b1;
    if (set_err_i)  err_d  = 1'b1;
    if (cnt_inc_i)  cnt_d  = cnt_q + LEN_W'(1);
  end

`ifdef DMA_IRQ_EN
  logic ie_q, irq_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_ctrl) ie_q <= wdata[CTRL_IE];
      irq_q <= ie_q && (done_q || err_q);
    end
  end
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    unique case (idx)
      REG_CTRL: begin
`ifdef DMA_IRQ_EN
        rd_val[CTRL_IE] = ie_q;
`endif
      end
      REG_SRC:    rd_val = DATA_W'(src_q);
      REG_DST:    rd_val = DATA_W'(dst_q);
      REG_LEN:    rd_val[LEN_W-1:0] = len_q;
      REG_STATUS: begin
        rd_val[ST_BUSY] = busy_i;
        rd_val[ST_DONE] = done_q;
        rd_val[ST_ERR]  = err_q;
      end
      REG_CNT:    rd_val[LEN_W-1:0] = cnt_q;
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (cfg_we && idx == REG_SRC) src_q <= ADDR_W'(wdata);
      if (cfg_we && idx == REG_DST) dst_q <= ADDR_W'(wdata);
      if (cfg_we && idx == REG_LEN) len_q <= wdata[LEN_W-1:0];
      cnt_q  <= cnt_d;
      done_q <= done_d;
      err_q  <= err_d;
      if (rd_en) rdata_q <= rd_val;
    end
  end

endmodule

// File: rtl/dma_csr_engine.sv
// dma_csr_engine: single-channel word-copy DMA with CSR slave port.
// Optional interrupt output enabled by defining DMA_IRQ_EN.
module dma_csr_engine
  import dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              irq
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              pend_q, pend_d;
  logic              busy, start, abort, set_done, set_err, cnt_inc;
  logic [ADDR_W-1:0] src, dst;
  logic [LEN_W-1:0]  len;

  dma_csr_regs #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .LEN_W (LEN_W)
  ) u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy_i    (busy),
    .set_done_i(set_done),
    .set_err_i (set_err),
    .cnt_inc_i (cnt_inc),
    .start_o   (start),
    .abort_o   (abort),
    .src_o     (src),
    .dst_o     (dst),
    .len_o     (len),
    .irq_o     (irq)
  );

  assign busy      = (state_q != IDLE);
  assign mem_req   = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign mem_we    = (state_q == WR_REQ);
  assign mem_addr  = mem_we ? dst_ptr_q : src_ptr_q;
  assign mem_wdata = wd_q;

  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    rem_d     = rem_q;
    wd_d      = wd_q;
    pend_d    = pend_q;
    set_done  = 1'b0;
    set_err   = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (start) begin
          if (src[1:0] != 2'b00 || dst[1:0] != 2'b00) begin
            set_err = 1'b1;
          end else if (len == '0) begin
            set_done = 1'b1;
          end else begin
            src_ptr_d = src;
            dst_ptr_d = dst;
            rem_d     = len;
            state_d   = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        // a read granted alongside ABORT must still drain its rvalid
        if (mem_gnt) begin
          state_d = RD_WAIT;
          pend_d  = abort;
        end else if (abort) begin
          state_d = IDLE;
          set_err = 1'b1;
        end
      end
      RD_WAIT: begin
        if (abort) pend_d = 1'b1;
        if (mem_rvalid) begin
          wd_d = mem_rdata;
          if (pend_q || abort) begin
            state_d = IDLE;
            set_err = 1'b1;
          end else begin
            state_d = WR_REQ;
          end
        end
      end
      WR_REQ: begin
        if (mem_gnt) begin
          src_ptr_d = src_ptr_q + ADDR_W'(4);
          dst_ptr_d = dst_ptr_q + ADDR_W'(4);
          rem_d     = rem_q - LEN_W'(1);
          cnt_inc   = 1'b1;
          if (abort) begin
            state_d = IDLE;
            set_err = 1'b1;
          end else if (rem_q == LEN_W'(1)) begin
            state_d = DONE_ST;
          end else begin
            state_d = RD_REQ;
          end
        end else if (abort) begin
          state_d = IDLE;
          set_err = 1'b1;
        end
      end
      DONE_ST: begin
        state_d  = IDLE;
        set_err  = abort;
        set_done = !abort;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      rem_q     <= '0;
      wd_q      <= '0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      rem_q     <= rem_d;
      wd_q      <= wd_d;
      pend_q    <= pend_d;
    end
  end

endmodule
